column_parity_stage: RTL and testbench
======================================

COLUMN_PARITY_STAGE -- requirements
Module: column_parity_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin one column-parity (theta) pass; honoured only in Idle.
REQ-005 dataIn  input  25  state slice z, bit index 5*y+x = lane (x,y); valid in the cycle after putInput.
REQ-006 ready  output  1  high only in Idle.
REQ-007 putInput  output  1  one-cycle request for the next input slice.
REQ-008 outReady  output  1  one-cycle pulse; result slices follow from the next cycle.
REQ-009 dataOut  output  25  theta result for the current emit slice; 25'd0 outside Emit.

Function
REQ-010 Parameters SHALL be: SLICES = 64, LANES = 25, ROWS = COLS = 5; slice index counter is 6 bits and wraps 63 to 0.
REQ-011 States SHALL be: Idle, Req, Cap, OutRdy, Emit.
REQ-012 Transitions SHALL be: Idle to Req on start; Req to Cap unconditionally; Cap to OutRdy if idx == 63, else to Req with idx+1; OutRdy to Emit with idx = 0; Emit to Idle if idx == 63, else idx+1.
REQ-013 Outputs SHALL be: ready = 1 in Idle; putInput = 1 in Req; outReady = 1 in OutRdy; all other outputs 0 in all other states.
REQ-014 In Cap, the block SHALL store dataIn into slice buffer[idx] and store the 5-bit column parity C[x][idx] = XOR over y of dataIn[5y+x].
REQ-015 Each slice SHALL cost exactly 2 cycles to load (Req, Cap): 64 putInput pulses, each followed by one non-request cycle.
REQ-016 In Emit slice z, dataOut[5y+x] SHALL equal buffer[z][5y+x] ^ C[(x+4)%5][z] ^ C[(x+1)%5][(z+63)%64].
REQ-017 Wrap-around: the term for z = 0 SHALL use the parity of slice 63.
REQ-018 Latency: outReady SHALL assert in the cycle after the 64th Cap, and the first result slice SHALL appear in the following cycle; ready SHALL re-assert in the cycle after the 64th Emit.
REQ-019 A start asserted outside Idle SHALL be ignored; a start held for several cycles SHALL launch only one pass.
REQ-020 Buffer and parity contents SHALL persist between passes and SHALL be fully overwritten before any use.

Reset
REQ-021 rst SHALL force Idle, idx = 0, ready = 1, putInput = 0, outReady = 0, dataOut = 0 immediately, including mid-load or mid-emit.
REQ-022 Buffer and parity storage SHALL NOT be reset.
REQ-023 The first pass after reset SHALL be fully correct.

Configuration
REQ-024 With macro COLUMN_PARITY_BYPASS_EN defined, the block SHALL have an extra input port bypass (1 bit), sampled on the accepted start; when the sampled value is 1, Emit SHALL output buffer[z] unmodified, with identical handshake timing.
REQ-025 Without COLUMN_PARITY_BYPASS_EN, the bypass port and its logic SHALL be absent and theta SHALL always be applied.

Structure
REQ-026 The shared package encoder_pkg SHALL hold SLICES, LANES, ROWS and the 6-bit slice-index width used by all encoder stages.
REQ-027 State encodings SHALL remain local to the block.
REQ-028 The combinational per-slice theta function (slice, C[z], C[z-1] to result) SHALL be a single sub-module, theta_slice.

Verification
REQ-029 All-zero input over 64 slices -> 64 output slices all 25'h0000000.
REQ-030 Slice 0 = 25'h0000001, all others 0 -> out slice 0 = 25'h0210843, out slice 1 = 25'h1084210, all others 0.
REQ-031 Slice 63 = 25'h0000001, all others 0 -> out slice 63 = 25'h0210843, out slice 0 = 25'h1084210 (wrap-around check).
REQ-032 Timing check -> exactly 64 putInput pulses spaced 2 cycles apart; a single outReady 1 cycle after the last Cap; 64 consecutive valid slices; ready high on the next cycle; a second start during Emit has no effect.
REQ-033 rst asserted after the 30th Cap -> ready = 1 and putInput = 0 immediately; a following full pass with the REQ-030 data reproduces the REQ-030 results.
REQ-034 With COLUMN_PARITY_BYPASS_EN defined and bypass = 1 at start, REQ-030 data -> out slice 0 = 25'h0000001, all other slices 0.

Source files
------------

// File: rtl/column_parity_stage_pkg.sv
// Shared encoder-stage constants, lane/slice types and the column-parity helper.
// Pure combinational definitions; no timing or flow control of their own.
package encoder_pkg;
  localparam int SLICES = 64;
  localparam int LANES  = 25;
  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int IDX_W  = 6;

  typedef logic [LANES-1:0] slice_t;
  typedef logic [COLS-1:0]  col_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Bit 5*y+x of a slice is lane (x,y); parity runs down each column x.
  function automatic col_t col_parity(input slice_t s);
    col_t p;
    p = '0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        p[x] = p[x] ^ s[COLS*y + x];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/column_parity_stage_if.sv
// Slice request/response handshake bundle for column_parity_stage.
// Carries the bypass control only when COLUMN_PARITY_BYPASS_EN is defined.
interface column_parity_stage_if;
  import encoder_pkg::*;

  logic   start;
  slice_t dataIn;
  logic   ready;
  logic   putInput;
  logic   outReady;
  slice_t dataOut;
`ifdef COLUMN_PARITY_BYPASS_EN
  logic   bypass;

  modport slave  (input  start, dataIn, bypass,
                  output ready, putInput, outReady, dataOut);
  modport master (output start, dataIn, bypass,
                  input  ready, putInput, outReady, dataOut);
`else
  modport slave  (input  start, dataIn,
                  output ready, putInput, outReady, dataOut);
  modport master (output start, dataIn,
                  input  ready, putInput, outReady, dataOut);
`endif
endinterface

// File: rtl/column_parity_stage_theta.sv
// Combinational theta for one slice: lane ^ C[x-1][z] ^ C[x+1][z-1].
// Zero latency, no flow control.
module theta_slice
  import encoder_pkg::*;
(
  input  slice_t i_slice,
  input  col_t   i_c_cur,
  input  col_t   i_c_prev,
  output slice_t o_theta
);
  always_comb begin
    o_theta = '0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        o_theta[COLS*y + x] = i_slice[COLS*y + x]
                            ^ i_c_cur[(x + COLS - 1) % COLS]
                            ^ i_c_prev[(x + 1) % COLS];
      end
    end
  end
endmodule

// File: rtl/column_parity_stage.sv
// Theta stage: loads 64 slices (2 cycles each), then streams 64 theta slices after an outReady pulse.
// Optional COLUMN_PARITY_BYPASS_EN adds a bypass input sampled on start that streams slices unmodified.
module column_parity_stage
  import encoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  column_parity_stage_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_OUTRDY,
    S_EMIT
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(SLICES - 1);

  state_t r_state;
  idx_t   r_idx;
  logic   r_ready;
  logic   r_put;
  logic   r_outrdy;
  slice_t r_dout;

  // Storage is intentionally not reset; every entry is rewritten before it is read.
  slice_t r_slice_mem [SLICES];
  col_t   r_par_mem   [SLICES];

  idx_t   w_emit_idx;
  idx_t   w_prev_idx;
  slice_t w_slice;
  col_t   w_c_cur;
  col_t   w_c_prev;
  slice_t w_theta;
  slice_t w_emit_dat;

  // dataOut is registered, so look up the slice that will be shown next cycle.
  assign w_emit_idx = (r_state == S_OUTRDY) ? '0 : r_idx + idx_t'(1);
  assign w_prev_idx = w_emit_idx - idx_t'(1);
  assign w_slice    = r_slice_mem[w_emit_idx];
  assign w_c_cur    = r_par_mem[w_emit_idx];
  assign w_c_prev   = r_par_mem[w_prev_idx];

  theta_slice u_theta (
    .i_slice  (w_slice),
    .i_c_cur  (w_c_cur),
    .i_c_prev (w_c_prev),
    .o_theta  (w_theta)
  );

`ifdef COLUMN_PARITY_BYPASS_EN
  logic r_bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bypass <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_bypass <= bus.bypass;
    end
  end

  assign w_emit_dat = r_bypass ? w_slice : w_theta;
`else
  assign w_emit_dat = w_theta;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_ready  <= 1'b1;
      r_put    <= 1'b0;
      r_outrdy <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_put    <= 1'b0;
      r_outrdy <= 1'b0;
      r_dout   <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_REQ;
            r_idx   <= '0;
            r_put   <= 1'b1;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          if (r_idx == LAST_IDX) begin
            r_state  <= S_OUTRDY;
            r_outrdy <= 1'b1;
          end else begin
            r_state <= S_REQ;
            r_idx   <= r_idx + idx_t'(1);
            r_put   <= 1'b1;
          end
        end
        S_OUTRDY: begin
          r_state <= S_EMIT;
          r_idx   <= '0;
          r_dout  <= w_emit_dat;
        end
        S_EMIT: begin
          r_idx <= r_idx + idx_t'(1);
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_dout <= w_emit_dat;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CAP) begin
      r_slice_mem[r_idx] <= bus.dataIn;
      r_par_mem[r_idx]   <= col_parity(bus.dataIn);
    end
  end

  assign bus.ready    = r_ready;
  assign bus.putInput = r_put;
  assign bus.outReady = r_outrdy;
  assign bus.dataOut  = r_dout;
endmodule

// File: tb/tb_column_parity_stage.sv
// Table-driven bench for column_parity_stage with an expected-slice queue scoreboard.
module tb_column_parity_stage;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  column_parity_stage_if bus();

  column_parity_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  slice_t stim [SLICES];
  slice_t exp_q [$];

  typedef struct {
    string  name;
    int     hot;
    slice_t val;
    int     e0;
    slice_t v0;
    int     e1;
    slice_t v1;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int z = 0; z < SLICES; z++) begin
      stim[z] = (z == v.hot) ? v.val : '0;
      exp_q.push_back((z == v.e0) ? v.v0 : ((z == v.e1) ? v.v1 : '0));
    end
  endtask

  // Independent reference: theta straight from the column-parity definition.
  function automatic slice_t theta_ref(input int z);
    col_t   pc;
    col_t   pp;
    slice_t r;
    int     zp;
    zp = (z + SLICES - 1) % SLICES;
    pc = '0;
    pp = '0;
    r  = '0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        pc[x] = pc[x] ^ stim[z][5*y + x];
        pp[x] = pp[x] ^ stim[zp][5*y + x];
      end
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        r[5*y + x] = stim[z][5*y + x] ^ pc[(x + 4) % 5] ^ pp[(x + 1) % 5];
    return r;
  endfunction

  task automatic run_pass(input string tag, input int hold);
    int     put_cnt;
    int     last_put;
    int     outrdy_cyc;
    int     outrdy_cnt;
    bit     done;
    slice_t exp;
    put_cnt = 0; last_put = -10; outrdy_cyc = -1; outrdy_cnt = 0; done = 1'b0;
    @(negedge clk);
    chk({tag, " ready_idle"}, {31'b0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (c == hold - 1) bus.start = 1'b0;
      if (bus.putInput) begin
        if (put_cnt > 0) chk({tag, " put_spacing"}, c - last_put, 32'd2);
        last_put = c;
        if (put_cnt < SLICES) bus.dataIn = stim[put_cnt];
        put_cnt++;
      end
      if (bus.outReady) begin
        outrdy_cnt++;
        if (outrdy_cyc < 0) begin
          chk({tag, " outrdy_lat"}, c - last_put, 32'd2);
          outrdy_cyc = c;
        end
      end else if (outrdy_cyc >= 0 && c > outrdy_cyc && c <= outrdy_cyc + SLICES) begin
        if (c == outrdy_cyc + 10) bus.start = 1'b1;
        if (c == outrdy_cyc + 11) bus.start = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk($sformatf("%s dout_z%0d", tag, c - outrdy_cyc - 1), {7'b0, bus.dataOut}, {7'b0, exp});
        chk({tag, " ready_in_emit"}, {31'b0, bus.ready}, 32'd0);
      end else if (outrdy_cyc >= 0 && c == outrdy_cyc + SLICES + 1) begin
        chk({tag, " ready_after_emit"}, {31'b0, bus.ready}, 32'd1);
        chk({tag, " dout_after_emit"}, {7'b0, bus.dataOut}, 32'd0);
        done = 1'b1;
      end else begin
        chk({tag, " dout_outside_emit"}, {7'b0, bus.dataOut}, 32'd0);
      end
    end
    bus.start = 1'b0;
    chk({tag, " completed"}, {31'b0, done}, 32'd1);
    chk({tag, " put_count"}, put_cnt, 32'd64);
    chk({tag, " outrdy_count"}, outrdy_cnt, 32'd1);
    chk({tag, " queue_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk({tag, " no_restart"}, {31'b0, bus.putInput}, 32'd0);
      chk({tag, " idle_ready"}, {31'b0, bus.ready}, 32'd1);
    end
  endtask

  task automatic run_abort();
    int put_cnt;
    bit aborted;
    put_cnt = 0; aborted = 1'b0;
    for (int z = 0; z < SLICES; z++) stim[z] = slice_t'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 200 && !aborted; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.putInput) begin
        if (put_cnt == 30) begin
          rst = 1'b1;
          #1;
          chk("abort ready", {31'b0, bus.ready}, 32'd1);
          chk("abort putInput", {31'b0, bus.putInput}, 32'd0);
          chk("abort outReady", {31'b0, bus.outReady}, 32'd0);
          chk("abort dataOut", {7'b0, bus.dataOut}, 32'd0);
          aborted = 1'b1;
        end else begin
          bus.dataIn = stim[put_cnt];
          put_cnt++;
        end
      end
    end
    chk("abort reached", {31'b0, aborted}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"zero",    -1, 25'h0,       -1, 25'h0,       -1, 25'h0};
    vecs[1] = '{"slice0",   0, 25'h0000001,  0, 25'h0210843,  1, 25'h1084210};
    vecs[2] = '{"slice63", 63, 25'h0000001, 63, 25'h0210843,  0, 25'h1084210};
    vecs[3] = '{"lane22",  10, 25'h0001000, 10, 25'h0843108, 11, 25'h0210842};
    vecs[4] = '{"even_col", 5, 25'h0000021,  5, 25'h0000021, -1, 25'h0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.dataIn  = '0;
`ifdef COLUMN_PARITY_BYPASS_EN
    bus.bypass  = 1'b0;
`endif
    #1;
    chk("rst ready", {31'b0, bus.ready}, 32'd1);
    chk("rst putInput", {31'b0, bus.putInput}, 32'd0);
    chk("rst outReady", {31'b0, bus.outReady}, 32'd0);
    chk("rst dataOut", {7'b0, bus.dataOut}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      run_pass(vecs[i].name, (i == 1) ? 4 : 1);
    end

    for (int z = 0; z < SLICES; z++) stim[z] = slice_t'($urandom);
    for (int z = 0; z < SLICES; z++) exp_q.push_back(theta_ref(z));
    run_pass("random", 1);

    run_abort();
    load_vec(vecs[1]);
    run_pass("post_rst", 1);

`ifdef COLUMN_PARITY_BYPASS_EN
    for (int z = 0; z < SLICES; z++) begin
      stim[z] = (z == 0) ? 25'h0000001 : '0;
      exp_q.push_back(stim[z]);
    end
    bus.bypass = 1'b1;
    run_pass("bypass", 1);
    bus.bypass = 1'b0;
    load_vec(vecs[1]);
    run_pass("bypass_off", 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
